// File: rtl/l2_msg1_queue.sv
// ----------------------------------------------------------------------------
// l2_msg1_queue
//   Circular-buffer FIFO that holds msg1 requests from the L1.5 cluster
//   arbiter until the L2 accepts them. The input side has no back-pressure:
//   a message that arrives while the queue is full (and nothing pops in that
//   cycle) is dropped and recorded in sticky overflow/drop statistics.
//
// Ports
//   clk, rst           clock, asynchronous active-low reset
//   in_type/data/tag/source  incoming msg1; in_type == MSG_TYPE_EMPTY is "no message"
//   out_ready          L2 accepts the head entry this cycle
//   clr_stat           clears overflow and drop_cnt at the next edge
//   out_valid          head entry present
//   out_type/data/tag/source  head entry (EMPTY / zero when out_valid is low)
//   count, full, empty occupancy status, derived from the registered count
//   overflow           sticky "a message was dropped"
//   drop_cnt           number of dropped messages, saturating at 255
// ----------------------------------------------------------------------------
module l2_msg1_queue #(
    parameter int unsigned          DEPTH          = 4,  // power of two, 2..16
    parameter int unsigned          CNT_W          = $clog2(DEPTH) + 1,
    parameter int unsigned          MSG_WIDTH      = 8,
    parameter int unsigned          DATA_WIDTH     = 64,
    parameter int unsigned          TAG_WIDTH      = 8,
    parameter int unsigned          OWNER_BITS     = 6,
    parameter logic [MSG_WIDTH-1:0] MSG_TYPE_EMPTY = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [MSG_WIDTH-1:0]  in_type,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic [TAG_WIDTH-1:0]  in_tag,
    input  logic [OWNER_BITS-1:0] in_source,
    input  logic                  out_ready,
    input  logic                  clr_stat,
    output logic                  out_valid,
    output logic [MSG_WIDTH-1:0]  out_type,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [TAG_WIDTH-1:0]  out_tag,
    output logic [OWNER_BITS-1:0] out_source,
    output logic [CNT_W-1:0]      count,
    output logic                  full,
    output logic                  empty,
    output logic                  overflow,
    output logic [7:0]            drop_cnt
);

    localparam int unsigned PTR_W   = $clog2(DEPTH);
    localparam int unsigned ENTRY_W = MSG_WIDTH + DATA_WIDTH + TAG_WIDTH + OWNER_BITS;

    // Storage is intentionally not reset; validity is tracked by count alone.
    logic [ENTRY_W-1:0] mem_q [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             overflow_q, overflow_d;
    logic [7:0]       drop_cnt_q, drop_cnt_d;

    logic               push;
    logic               pop;
    logic               wr_en;
    logic               drop;
    logic [ENTRY_W-1:0] entry_in;
    logic [ENTRY_W-1:0] head;

    // ------------------------------------------------------------------
    // Status and handshake decode
    // ------------------------------------------------------------------
    always_comb begin
        full      = (count_q == CNT_W'(DEPTH));
        empty     = (count_q == '0);
        count     = count_q;
        out_valid = !empty;

        push  = (in_type != MSG_TYPE_EMPTY);
        pop   = out_valid && out_ready;
        // A pop in the same cycle frees the slot the push lands in.
        wr_en = push && (!full || pop);
        drop  = push && full && !pop;
    end

    assign entry_in = {in_type, in_data, in_tag, in_source};
    assign head     = mem_q[rd_ptr_q];

    // Head fields are masked so an empty queue presents a clean EMPTY message.
    always_comb begin
        out_type   = MSG_TYPE_EMPTY;
        out_data   = '0;
        out_tag    = '0;
        out_source = '0;
        if (out_valid) begin
            {out_type, out_data, out_tag, out_source} = head;
        end
    end

    // ------------------------------------------------------------------
    // Next-state: pointers, occupancy, statistics
    // ------------------------------------------------------------------
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        // DEPTH is a power of two, so natural overflow gives the modulo wrap.
        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end

        unique case ({wr_en, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        overflow_d = overflow_q;
        drop_cnt_d = drop_cnt_q;
        // A drop in the clearing cycle wins: the stats restart at one drop.
        if (drop) begin
            overflow_d = 1'b1;
            if (clr_stat) begin
                drop_cnt_d = 8'd1;
            end else if (drop_cnt_q != 8'hFF) begin
                drop_cnt_d = drop_cnt_q + 8'd1;
            end
        end else if (clr_stat) begin
            overflow_d = 1'b0;
            drop_cnt_d = 8'd0;
        end
    end

    assign overflow = overflow_q;
    assign drop_cnt = drop_cnt_q;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            drop_cnt_q <= 8'd0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= entry_in;
        end
    end

endmodule

// File: tb/tb_l2_msg1_queue.sv
// ----------------------------------------------------------------------------
// tb_l2_msg1_queue
//   Self-checking bench for l2_msg1_queue: a table of directed vectors, a few
//   hand-written multi-cycle sequences (async reset, drop saturation) and a
//   randomized run checked against a queue-based reference model.
// ----------------------------------------------------------------------------
module tb_l2_msg1_queue;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned CNT_W = 3;
    localparam logic [7:0]  LOAD  = 8'd19;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [7:0]  in_type = '0;
    logic [63:0] in_data = '0;
    logic [7:0]  in_tag = '0;
    logic [5:0]  in_source = '0;
    logic        out_ready = 1'b0;
    logic        clr_stat = 1'b0;
    logic        out_valid;
    logic [7:0]  out_type;
    logic [63:0] out_data;
    logic [7:0]  out_tag;
    logic [5:0]  out_source;
    logic [CNT_W-1:0] count;
    logic        full;
    logic        empty;
    logic        overflow;
    logic [7:0]  drop_cnt;

    l2_msg1_queue #(
        .DEPTH      (DEPTH),
        .CNT_W      (CNT_W),
        .MSG_WIDTH  (8),
        .DATA_WIDTH (64),
        .TAG_WIDTH  (8),
        .OWNER_BITS (6)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_type    (in_type),
        .in_data    (in_data),
        .in_tag     (in_tag),
        .in_source  (in_source),
        .out_ready  (out_ready),
        .clr_stat   (clr_stat),
        .out_valid  (out_valid),
        .out_type   (out_type),
        .out_data   (out_data),
        .out_tag    (out_tag),
        .out_source (out_source),
        .count      (count),
        .full       (full),
        .empty      (empty),
        .overflow   (overflow),
        .drop_cnt   (drop_cnt)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Advance one clock edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [7:0] t, input logic [7:0] g, input logic [63:0] d,
                         input logic [5:0] s, input logic r, input logic c);
        in_type   = t;
        in_tag    = g;
        in_data   = d;
        in_source = s;
        out_ready = r;
        clr_stat  = c;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        drive(8'd0, 8'd0, 64'd0, 6'd0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    // ------------------------------------------------------------------
    // Reference model: a plain queue plus statistics
    // ------------------------------------------------------------------
    typedef struct packed {
        logic [7:0]  t;
        logic [63:0] d;
        logic [7:0]  g;
        logic [5:0]  s;
    } ent_t;

    ent_t mq[$];
    logic m_ovf;
    int   m_drop;

    task automatic model_reset();
        mq.delete();
        m_ovf  = 1'b0;
        m_drop = 0;
    endtask

    task automatic model_step(input ent_t e, input logic rdy, input logic clr);
        bit pop_now;
        bit push_now;
        bit drop_now;
        pop_now  = (mq.size() != 0) && rdy;
        push_now = (e.t != 8'd0);
        drop_now = push_now && (mq.size() == DEPTH) && !pop_now;
        if (pop_now) void'(mq.pop_front());
        if (push_now && !drop_now) mq.push_back(e);
        if (drop_now) begin
            m_ovf  = 1'b1;
            m_drop = clr ? 1 : ((m_drop < 255) ? m_drop + 1 : 255);
        end else if (clr) begin
            m_ovf  = 1'b0;
            m_drop = 0;
        end
    endtask

    task automatic model_check(input string nm);
        ent_t h;
        h = (mq.size() != 0) ? mq[0] : '0;
        chk({nm, ".valid"}, 64'(out_valid), 64'(mq.size() != 0));
        chk({nm, ".head"}, {out_type, out_data[39:0], out_tag, out_source},
            {h.t, h.d[39:0], h.g, h.s});
        chk({nm, ".data"}, out_data, h.d);
        chk({nm, ".count"}, 64'(count), 64'(mq.size()));
        chk({nm, ".flags"}, {full, empty, overflow}, {mq.size() == DEPTH, mq.size() == 0, m_ovf});
        chk({nm, ".drop"}, 64'(drop_cnt), 64'(m_drop));
    endtask

    // ------------------------------------------------------------------
    // Directed vector table
    // ------------------------------------------------------------------
    typedef struct {
        logic [7:0]  t;
        logic [7:0]  g;
        logic [63:0] d;
        logic [5:0]  s;
        logic        rdy;
        logic        clr;
        logic        ev;
        logic [7:0]  etag;
        logic [63:0] edata;
        logic [5:0]  esrc;
        int          ecnt;
        logic        eovf;
        int          edrop;
    } vec_t;

    vec_t vq[$];

    task automatic add(input logic [7:0] t, input logic [7:0] g, input logic [63:0] d,
                       input logic [5:0] s, input logic rdy, input logic clr,
                       input logic ev, input logic [7:0] etag, input logic [63:0] edata,
                       input logic [5:0] esrc, input int ecnt, input logic eovf,
                       input int edrop);
        vec_t v;
        v = '{t, g, d, s, rdy, clr, ev, etag, edata, esrc, ecnt, eovf, edrop};
        vq.push_back(v);
    endtask

    task automatic build_table();
        // Single message held for three cycles, then popped.
        add(LOAD, 8'd3, 64'h5A, 6'd2, 0, 0,   1, 8'd3, 64'h5A, 6'd2, 1, 0, 0);
        for (int i = 0; i < 3; i++)
            add(8'd0, 8'd0, 64'd0, 6'd0, 0, 0, 1, 8'd3, 64'h5A, 6'd2, 1, 0, 0);
        add(8'd0, 8'd0, 64'd0, 6'd0, 1, 0,    0, 8'd0, 64'd0, 6'd0, 0, 0, 0);
        // Fill with tags 0..3.
        for (int i = 0; i < 4; i++)
            add(LOAD, 8'(i), 64'h100 + 64'(i), 6'(i), 0, 0,
                1, 8'd0, 64'h100, 6'd0, i + 1, 0, 0);
        // Drop while full, then push-with-pop while full, then clear stats.
        add(LOAD, 8'd7, 64'h107, 6'd7, 0, 0,  1, 8'd0, 64'h100, 6'd0, 4, 1, 1);
        add(LOAD, 8'd8, 64'h108, 6'd8, 1, 0,  1, 8'd1, 64'h101, 6'd1, 4, 1, 1);
        add(8'd0, 8'd0, 64'd0, 6'd0, 0, 1,    1, 8'd1, 64'h101, 6'd1, 4, 0, 0);
        // Drain in order: 2, 3, 8, then empty; out_ready while empty is ignored.
        add(8'd0, 8'd0, 64'd0, 6'd0, 1, 0,    1, 8'd2, 64'h102, 6'd2, 3, 0, 0);
        add(8'd0, 8'd0, 64'd0, 6'd0, 1, 0,    1, 8'd3, 64'h103, 6'd3, 2, 0, 0);
        add(8'd0, 8'd0, 64'd0, 6'd0, 1, 0,    1, 8'd8, 64'h108, 6'd8, 1, 0, 0);
        add(8'd0, 8'd0, 64'd0, 6'd0, 1, 0,    0, 8'd0, 64'd0, 6'd0, 0, 0, 0);
        add(8'd0, 8'd0, 64'd0, 6'd0, 1, 0,    0, 8'd0, 64'd0, 6'd0, 0, 0, 0);
        // Wrap-around: count held at 1 with continuous push/pop.
        add(LOAD, 8'h10, 64'h210, 6'h10, 0, 0, 1, 8'h10, 64'h210, 6'h10, 1, 0, 0);
        for (int i = 1; i <= 6; i++)
            add(LOAD, 8'h10 + 8'(i), 64'h210 + 64'(i), 6'h10 + 6'(i), 1, 0,
                1, 8'h10 + 8'(i), 64'h210 + 64'(i), 6'h10 + 6'(i), 1, 0, 0);
        add(8'd0, 8'd0, 64'd0, 6'd0, 1, 0,    0, 8'd0, 64'd0, 6'd0, 0, 0, 0);
        // Drop, then drop coinciding with clr_stat (drop wins, count restarts at 1).
        for (int i = 0; i < 4; i++)
            add(LOAD, 8'h20 + 8'(i), 64'h320 + 64'(i), 6'(i), 0, 0,
                1, 8'h20, 64'h320, 6'd0, i + 1, 0, 0);
        add(LOAD, 8'h24, 64'h324, 6'd4, 0, 0, 1, 8'h20, 64'h320, 6'd0, 4, 1, 1);
        add(LOAD, 8'h25, 64'h325, 6'd5, 0, 0, 1, 8'h20, 64'h320, 6'd0, 4, 1, 2);
        add(LOAD, 8'h26, 64'h326, 6'd6, 0, 1, 1, 8'h20, 64'h320, 6'd0, 4, 1, 1);
        add(8'd0, 8'd0, 64'd0, 6'd0, 0, 1,    1, 8'h20, 64'h320, 6'd0, 4, 0, 0);
    endtask

    // ------------------------------------------------------------------
    // Main sequence
    // ------------------------------------------------------------------
    initial begin
        do_reset();
        chk("reset.valid", 64'(out_valid), 64'd0);
        chk("reset.type", 64'(out_type), 64'd0);
        chk("reset.flags", {count, full, empty, overflow, drop_cnt}, {3'd0, 1'b0, 1'b1, 1'b0, 8'd0});

        // Directed table.
        build_table();
        foreach (vq[i]) begin
            drive(vq[i].t, vq[i].g, vq[i].d, vq[i].s, vq[i].rdy, vq[i].clr);
            tick();
            chk($sformatf("vec%0d.valid", i), 64'(out_valid), 64'(vq[i].ev));
            chk($sformatf("vec%0d.type", i), 64'(out_type), 64'(vq[i].ev ? LOAD : 8'd0));
            chk($sformatf("vec%0d.fields", i), {out_data[47:0], out_tag, out_source},
                {vq[i].edata[47:0], vq[i].etag, vq[i].esrc});
            chk($sformatf("vec%0d.count", i), 64'(count), 64'(vq[i].ecnt));
            chk($sformatf("vec%0d.fe", i), {full, empty},
                {vq[i].ecnt == DEPTH, vq[i].ecnt == 0});
            chk($sformatf("vec%0d.stat", i), {overflow, drop_cnt},
                {vq[i].eovf, 8'(vq[i].edrop)});
        end

        // Asynchronous reset between edges with three entries queued.
        do_reset();
        for (int i = 0; i < 3; i++) begin
            drive(LOAD, 8'h40 + 8'(i), 64'h40, 6'd1, 0, 0);
            tick();
        end
        drive(8'd0, 8'd0, 64'd0, 6'd0, 0, 0);
        chk("areset.pre_count", 64'(count), 64'd3);
        #3;
        rst = 1'b0;
        #1;
        chk("areset.valid", 64'(out_valid), 64'd0);
        chk("areset.head", {out_type, out_data[31:0], out_tag, out_source}, '0);
        chk("areset.flags", {count, full, empty, overflow, drop_cnt}, {3'd0, 1'b0, 1'b1, 1'b0, 8'd0});
        #2;
        rst = 1'b1;
        drive(LOAD, 8'd5, 64'h55, 6'd3, 0, 0);
        tick();
        drive(8'd0, 8'd0, 64'd0, 6'd0, 0, 0);
        chk("areset.post_tag", {out_valid, out_tag, out_data[15:0]}, {1'b1, 8'd5, 16'h55});
        chk("areset.post_count", 64'(count), 64'd1);

        // Drop counter saturation.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            drive(LOAD, 8'(i), 64'd0, 6'd0, 0, 0);
            tick();
        end
        for (int i = 0; i < 260; i++) begin
            drive(LOAD, 8'hEE, 64'hEE, 6'd9, 0, 0);
            tick();
            if (i == 253) chk("sat.mid", 64'(drop_cnt), 64'd254);
        end
        drive(8'd0, 8'd0, 64'd0, 6'd0, 0, 0);
        chk("sat.drop", 64'(drop_cnt), 64'd255);
        chk("sat.ovf", {overflow, count, out_tag}, {1'b1, 3'd4, 8'd0});

        // Randomized run against the reference model, several push/pop mixes.
        do_reset();
        model_reset();
        model_check("rand.reset");
        for (int p = 0; p < 4; p++) begin
            int push_pct;
            int rdy_pct;
            push_pct = (p == 0) ? 80 : (p == 1) ? 30 : (p == 2) ? 60 : 95;
            rdy_pct  = (p == 0) ? 30 : (p == 1) ? 80 : (p == 2) ? 60 : 10;
            for (int c = 0; c < 400; c++) begin
                ent_t e;
                logic r;
                logic cl;
                e.t = ($urandom_range(99) < push_pct) ? 8'($urandom_range(255, 1)) : 8'd0;
                e.d = {$urandom, $urandom};
                e.g = 8'($urandom);
                e.s = 6'($urandom);
                r   = ($urandom_range(99) < rdy_pct);
                cl  = ($urandom_range(99) < 3);
                drive(e.t, e.g, e.d, e.s, r, cl);
                model_step(e, r, cl);
                tick();
                model_check($sformatf("rand%0d.%0d", p, c));
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/l2_msg1_queue.md
L2_MSG1_QUEUE -- requirements
Module: l2_msg1_queue

Interface
REQ-001 Parameter DEPTH, 4, number of queue entries; power of two, 2..16.
REQ-002 Parameter CNT_W, $clog2(DEPTH)+1, occupancy counter width.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 rst  input  1  asynchronous active-low reset.
REQ-005 in_type  input  MSG_WIDTH  msg1 type from the L1.5 cluster arbiter.
REQ-006 in_data  input  DATA_WIDTH  msg1 data.
REQ-007 in_tag  input  TAG_WIDTH  msg1 tag.
REQ-008 in_source  input  OWNER_BITS  originating core index.
REQ-009 out_ready  input  1  L2 accepts the head entry this cycle.
REQ-010 clr_stat  input  1  synchronous clear of overflow and drop_cnt.
REQ-011 out_valid  output  1  head entry is present.
REQ-012 out_type, out_data, out_tag, out_source  output  MSG_WIDTH/DATA_WIDTH/TAG_WIDTH/OWNER_BITS  head entry fields.
REQ-013 count  output  CNT_W  current occupancy.
REQ-014 full, empty  output  1  occupancy == DEPTH and occupancy == 0, respectively.
REQ-015 overflow  output  1  sticky flag: a message was dropped.
REQ-016 drop_cnt  output  8  number of dropped messages, saturating.

Function
REQ-017 Push occurs in any cycle where in_type != MSG_TYPE_EMPTY; the input has no stall and no handshake.
REQ-018 Pop occurs in any cycle where out_valid && out_ready.
REQ-019 Ordering is strict FIFO; entry fields type/data/tag/source are stored and returned unmodified.
REQ-020 There is no bypass path; an entry pushed at edge N is visible on the outputs from cycle N+1.
REQ-021 out_valid = !empty; when out_valid is 0, out_type = MSG_TYPE_EMPTY and out_data/out_tag/out_source = 0.
REQ-022 Head fields remain stable while out_valid && !out_ready.
REQ-023 Storage is a circular buffer with wr_ptr and rd_ptr of width log2(DEPTH), each incrementing modulo DEPTH (DEPTH-1 wraps to 0).
REQ-024 count updates as follows: +1 on push only; -1 on pop only; unchanged on simultaneous push and pop.
REQ-025 Push while empty with out_ready=1 is accepted; nothing pops that cycle; count becomes 1.
REQ-026 Push while full with a pop in the same cycle is accepted; count stays DEPTH.
REQ-027 Push while full with no pop is dropped:
- storage and pointers are unchanged;
- overflow is set to 1;
- drop_cnt increments, saturating at 255.
REQ-028 out_ready while empty is ignored; count is not decremented below 0.
REQ-029 clr_stat=1 clears overflow and drop_cnt at the next edge; a drop in the same cycle takes priority (overflow=1, drop_cnt=1).
REQ-030 full, empty and count are derived combinationally from the registered count.

Reset
REQ-031 rst=0 asynchronously forces the following, regardless of clk:
- wr_ptr=0, rd_ptr=0, count=0;
- overflow=0, drop_cnt=0;
- out_valid=0, out_type=MSG_TYPE_EMPTY, out_data=0, out_tag=0, out_source=0;
- empty=1, full=0.
REQ-032 Reset asserted mid-operation discards all queued entries; storage contents need not be cleared.
REQ-033 After rst deasserts, the first rising edge may push.

Verification
REQ-034 Single message: push type=MSG_TYPE_LOAD_MEM, tag=3, data=0x5A, source=2 with out_ready=0 -> next cycle out_valid=1, fields match, count=1; hold 3 cycles -> fields stable.
REQ-035 Fill and order: 4 consecutive pushes with tags 0,1,2,3 and out_ready=0 -> full=1, count=4; then out_ready=1 -> tags pop in order 0,1,2,3 over 4 cycles, then empty=1 and out_type=MSG_TYPE_EMPTY.
REQ-036 Overflow: with the queue full, push tag=7 with out_ready=0 -> dropped, overflow=1, drop_cnt=1, head tag still 0; push again while full with out_ready=1 -> accepted, count=4, drop_cnt=1; then clr_stat=1 -> overflow=0, drop_cnt=0.
REQ-037 Wrap-around: 6 push/pop cycles with continuous push and out_ready=1 from count=1 -> count stays 1, pointers wrap, output sequence is in-order with no loss.
REQ-038 Async reset: with count=3, assert rst=0 between clock edges -> outputs reach reset values immediately, before the next edge; after release, a push of tag=5 appears as the head with count=1.
REQ-039 Saturation: 260 drops while full -> drop_cnt=255, overflow=1.
